// File: rtl/online_pkg.sv
// -----------------------------------------------------------------------------
// online_pkg
// Shared definitions for the online_host block and its reference checker:
//   - word / result widths and counts
//   - FSM state type and state encodings
//   - res_err completion codes
//   - sx8(): sign-extends an 8-bit two's-complement part to the 18-bit width
//     used by the complex-product arithmetic
// No ports (package).
// -----------------------------------------------------------------------------
package online_pkg;

    localparam int WORD_W    = 16;
    localparam int RES_W     = 36;
    localparam int NUM_WORDS = 4;
    localparam int NUM_RES   = 3;
    localparam int HALF_W    = RES_W / 2;   // width of one real/imag component

    // FSM state type; encodings kept as plain constants.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SEND = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_RECV = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Completion codes reported on res_err.
    typedef logic [1:0] err_t;
    localparam err_t ERR_OK      = 2'd0;
    localparam err_t ERR_TIMEOUT = 2'd1;
    localparam err_t ERR_SHORT   = 2'd2;
    localparam err_t ERR_EARLY   = 2'd3;

    // Sign-extend an 8-bit signed component to HALF_W bits so every product
    // and sum below is evaluated at full result width.
    function automatic logic [HALF_W-1:0] sx8(input logic [7:0] v);
        return {{(HALF_W-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/online_ref_model.sv
// -----------------------------------------------------------------------------
// online_ref_model
// Purely combinational expected-result generator for online_host. Given the
// latched job mode and data it produces the three 36-bit results the DUT is
// expected to return.
//   mode 0: words 0,1 = A0,A1 and words 2,3 = B0,B1, each word holding
//           real = signed [15:8], imag = signed [7:0]. Results are the
//           coefficients of conj-weighted product sum, packed {R[17:0],I[17:0]}.
//   mode 1: over all 16 nibbles -> max, min, max-min (zero-extended).
// Ports:
//   mode_i  - job mode
//   data_i  - 64-bit job data, word k at [16k+15:16k]
//   exp_o   - expected results, result k at [36k+35:36k]
// -----------------------------------------------------------------------------
module online_ref_model
    import online_pkg::*;
(
    input  logic                     mode_i,
    input  logic [NUM_WORDS*WORD_W-1:0] data_i,
    output logic [NUM_RES*RES_W-1:0] exp_o
);

    // Components, sign-extended to HALF_W so truncation never loses sign.
    logic signed [HALF_W-1:0] ar0, ai0, ar1, ai1;
    logic signed [HALF_W-1:0] br0, bi0, br1, bi1;

    assign ar0 = sx8(data_i[15:8]);
    assign ai0 = sx8(data_i[7:0]);
    assign ar1 = sx8(data_i[31:24]);
    assign ai1 = sx8(data_i[23:16]);
    assign br0 = sx8(data_i[47:40]);
    assign bi0 = sx8(data_i[39:32]);
    assign br1 = sx8(data_i[63:56]);
    assign bi1 = sx8(data_i[55:48]);

    logic signed [HALF_W-1:0] r0, r1, r2, i0, i1, i2;

    always_comb begin
        r0 = ar0 * br0 + ai0 * bi0;
        r1 = ar0 * br1 + ai0 * bi1 + ar1 * br0 + ai1 * bi0;
        r2 = ar1 * br1 + ai1 * bi1;
        i0 = ar0 * bi0 - ai0 * br0;
        i1 = ar0 * bi1 - ai0 * br1 + ar1 * bi0 - ai1 * br0;
        i2 = ar1 * bi1 - ai1 * br1;
    end

    // Nibble extremes across all 64 data bits.
    logic [3:0] nib_max;
    logic [3:0] nib_min;
    logic [3:0] nib_rng;

    always_comb begin
        nib_max = 4'h0;
        nib_min = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (data_i[4*i +: 4] > nib_max) nib_max = data_i[4*i +: 4];
            if (data_i[4*i +: 4] < nib_min) nib_min = data_i[4*i +: 4];
        end
    end

    assign nib_rng = nib_max - nib_min;

    always_comb begin
        if (mode_i) begin
            exp_o = {{(RES_W-4){1'b0}}, nib_rng,
                     {(RES_W-4){1'b0}}, nib_min,
                     {(RES_W-4){1'b0}}, nib_max};
        end else begin
            exp_o = {r2, i2, r1, i1, r0, i0};
        end
    end

endmodule

// File: rtl/online_host.sv
// -----------------------------------------------------------------------------
// online_host
// Drives a 4-word job into a streaming DUT, collects its 3-word answer and
// reports completion status.
//   IDLE -> SEND (4 words) -> WAIT (first out_valid or timeout)
//        -> RECV (results 1,2) -> DONE (one-cycle res_valid) -> IDLE
// Optional build macro: ONLINE_HOST_CHECK_EN. When defined, an
// online_ref_model instance computes expected results and res_mismatch flags
// a disagreement on error-free jobs. When undefined, res_mismatch is tied 0.
// Parameters:
//   TIMEOUT       - idle cycles waited in WAIT for the first dut_out_valid
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   job_valid/job_ready/job_mode/job_data - job request handshake
//   dut_in_valid/dut_in_mode/dut_in       - stimulus to the DUT
//   dut_out_valid/dut_out                 - response from the DUT
//   res_valid     - one-cycle completion pulse
//   res_data      - captured results, result k at [36k+35:36k]
//   res_err       - 0 ok, 1 timeout, 2 short burst, 3 early output
//   res_mismatch  - checker disagreement (0 if checker not built)
// -----------------------------------------------------------------------------
module online_host
    import online_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic                         job_mode,
    input  logic [NUM_WORDS*WORD_W-1:0]  job_data,
    output logic                         dut_in_valid,
    output logic                         dut_in_mode,
    output logic [WORD_W-1:0]            dut_in,
    input  logic                         dut_out_valid,
    input  logic [RES_W-1:0]             dut_out,
    output logic                         res_valid,
    output logic [NUM_RES*RES_W-1:0]     res_data,
    output logic [1:0]                   res_err,
    output logic                         res_mismatch
);

    // One counter serves as word index in SEND, idle counter in WAIT and
    // result index in RECV, so it must hold both 3 and TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 4) ? $clog2(TIMEOUT) : 2;
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SEND_LAST = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          mode_q, mode_d;
    logic [NUM_WORDS*WORD_W-1:0]   data_q, data_d;
    logic [NUM_RES*RES_W-1:0]      cap_q, cap_d;
    err_t                          err_q, err_d;
    logic [NUM_RES*RES_W-1:0]      res_data_q;
    err_t                          res_err_q;

    // Split the latched job into its words for the SEND mux.
    logic [WORD_W-1:0] word_w [NUM_WORDS];

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        assign word_w[gi] = data_q[gi*WORD_W +: WORD_W];
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        cap_d   = cap_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    mode_d  = job_mode;
                    data_d  = job_data;
                    cap_d   = '0;
                    err_d   = ERR_OK;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                // Output before the job is fully sent is flagged but the
                // transfer still completes so the DUT sees a whole job.
                if (dut_out_valid) err_d = ERR_EARLY;
                if (cnt_q == CNT_SEND_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_WAIT: begin
                if (dut_out_valid) begin
                    cap_d[0 +: RES_W] = dut_out;
                    cnt_d             = CNT_ONE;
                    state_d           = ST_RECV;
                end else if (cnt_q == CNT_WAIT_LAST) begin
                    // An earlier early-output error takes precedence.
                    if (err_q != ERR_EARLY) err_d = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_RECV: begin
                if (dut_out_valid) begin
                    if (cnt_q == CNT_ONE) begin
                        cap_d[RES_W +: RES_W] = dut_out;
                        cnt_d                 = cnt_q + CNT_ONE;
                    end else begin
                        cap_d[2*RES_W +: RES_W] = dut_out;
                        state_d                 = ST_DONE;
                    end
                end else begin
                    if (err_q != ERR_EARLY) err_d = ERR_SHORT;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and working registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            cap_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    // Published results change only on entry to DONE, so they are valid
    // alongside res_valid and stay put until the next job completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q <= '0;
            res_err_q  <= ERR_OK;
        end else if (state_d == ST_DONE) begin
            res_data_q <= cap_d;
            res_err_q  <= err_d;
        end
    end

`ifdef ONLINE_HOST_CHECK_EN
    logic [NUM_RES*RES_W-1:0] exp_w;
    logic                     mismatch_q;

    online_ref_model u_ref_model (
        .mode_i (mode_q),
        .data_i (data_q),
        .exp_o  (exp_w)
    );

    // Only error-free jobs are compared; a faulty transfer says nothing
    // about arithmetic correctness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else if (state_d == ST_DONE) begin
            mismatch_q <= (err_d == ERR_OK) && (cap_d != exp_w);
        end
    end

    assign res_mismatch = mismatch_q;
`else
    assign res_mismatch = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign job_ready    = (state_q == ST_IDLE);
    assign dut_in_valid = (state_q == ST_SEND);
    assign dut_in_mode  = (state_q == ST_SEND) && (cnt_q == '0) && mode_q;
    assign dut_in       = (state_q == ST_SEND) ? word_w[cnt_q[1:0]] : '0;
    assign res_valid    = (state_q == ST_DONE);
    assign res_data     = res_data_q;
    assign res_err      = res_err_q;

endmodule

// File: tb/tb_online_host.sv
module tb_online_host;

    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic          job_mode;
    logic [63:0]   job_data;
    logic          dut_in_valid;
    logic          dut_in_mode;
    logic [15:0]   dut_in;
    logic          dut_out_valid;
    logic [35:0]   dut_out;
    logic          res_valid;
    logic [107:0]  res_data;
    logic [1:0]    res_err;
    logic          res_mismatch;

    int total;
    int bad;

    online_host #(.TIMEOUT(TO)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_mode      (job_mode),
        .job_data      (job_data),
        .dut_in_valid  (dut_in_valid),
        .dut_in_mode   (dut_in_mode),
        .dut_in        (dut_in),
        .dut_out_valid (dut_out_valid),
        .dut_out       (dut_out),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_err       (res_err),
        .res_mismatch  (res_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a job and check the four SEND cycles. Returns at the negedge of
    // word 3. early: pulse dut_out_valid during word 1. abort_at: word index
    // at which rst_n is pulled low (4 = never).
    task automatic start_job(input logic m, input logic [63:0] d,
                             input logic early, input int abort_at);
        logic [15:0] w;
        @(negedge clk);
        total++;
        if (job_ready !== 1'b1) begin
            bad++;
            $display("FAIL job_ready_before_accept got=%0b want=1", job_ready);
        end
        job_valid = 1'b1;
        job_mode  = m;
        job_data  = d;
        @(negedge clk);
        job_valid = 1'b0;
        job_mode  = ~m;
        job_data  = ~d;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                dut_out_valid = 1'b0;
            end
            w = d[16*k +: 16];
            total++;
            if ({dut_in_valid, dut_in_mode, dut_in} !== {1'b1, (k == 0) ? m : 1'b0, w}) begin
                bad++;
                $display("FAIL send_word%0d got v=%0b m=%0b d=%h want v=1 m=%0b d=%h",
                         k, dut_in_valid, dut_in_mode, dut_in, (k == 0) ? m : 1'b0, w);
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                total++;
                if ({dut_in_valid, job_ready, res_valid} !== 3'b010) begin
                    bad++;
                    $display("FAIL reset_mid_send got in_valid=%0b ready=%0b res_valid=%0b want 0 1 0",
                             dut_in_valid, job_ready, res_valid);
                end
                return;
            end
            if (early && k == 1) begin
                dut_out_valid = 1'b1;
                dut_out       = 36'h123;
            end
        end
    endtask

    // Model DUT: n consecutive out_valid cycles starting in the first WAIT cycle.
    task automatic respond(input int n, input logic [35:0] v0, input logic [35:0] v1,
                           input logic [35:0] v2);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            dut_out_valid = 1'b1;
            dut_out       = (i == 0) ? v0 : (i == 1) ? v1 : v2;
            @(negedge clk);
        end
        dut_out_valid = 1'b0;
        dut_out       = '0;
    endtask

    // Bounded wait for res_valid; cyc = negedges waited.
    task automatic wait_done(output int cyc, output bit seen);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        seen = (res_valid === 1'b1);
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        job_valid     = 1'b0;
        job_mode      = 1'b0;
        job_data      = '0;
        dut_out_valid = 1'b0;
        dut_out       = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({job_ready, dut_in_valid, dut_in_mode, dut_in, res_valid} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_ctrl got ready=%0b in_v=%0b in_m=%0b in=%h res_v=%0b want 1 0 0 0000 0",
                     job_ready, dut_in_valid, dut_in_mode, dut_in, res_valid);
        end
        total++;
        if ({res_data, res_err, res_mismatch} !== '0) begin
            bad++;
            $display("FAIL reset_res got data=%h err=%0d mm=%0b want 0 0 0", res_data, res_err, res_mismatch);
        end
        rst_n = 1'b1;
        $display("reset: checked");
    endtask

    // Shared post-completion checks are inlined per test; this one covers mode 1.
    task automatic test_mode1;
        int cyc; bit seen;
        logic [107:0] want;
        want = {36'd15, 36'd0, 36'd15};
        start_job(1'b1, {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, 1'b0, 4);
        respond(3, 36'd15, 36'd0, 36'd15);
        wait_done(cyc, seen);
        total++;
        if (!seen || cyc != 0) begin
            bad++;
            $display("FAIL mode1_latency got seen=%0b cyc=%0d want 1 0", seen, cyc);
        end
        total++;
        if ({res_data, res_err, res_mismatch, job_ready} !== {want, 2'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mode1_result got data=%h err=%0d mm=%0b ready=%0b want %h 0 0 0",
                     res_data, res_err, res_mismatch, job_ready, want);
        end
        @(negedge clk);
        total++;
        if ({res_valid, job_ready, res_data} !== {1'b0, 1'b1, want}) begin
            bad++;
            $display("FAIL mode1_after got res_v=%0b ready=%0b data=%h want 0 1 %h",
                     res_valid, job_ready, res_data, want);
        end
        $display("mode1: data=%h err=%0d mm=%0b", res_data, res_err, res_mismatch);
    endtask

    task automatic test_mode0;
        int cyc; bit seen;
        logic [107:0] prev, want;
        prev = res_data;
        want = {36'd0, 36'd0, 36'h000080000};
        start_job(1'b0, {16'h0000, 16'h0200, 16'h0000, 16'h0100}, 1'b0, 4);
        total++;
        if (res_data !== prev) begin
            bad++;
            $display("FAIL mode0_hold got data=%h want %h", res_data, prev);
        end
        respond(3, 36'h000080000, 36'd0, 36'd0);
        wait_done(cyc, seen);
        total++;
        if (!seen || {res_data, res_err, res_mismatch} !== {want, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL mode0_result got seen=%0b data=%h err=%0d mm=%0b want 1 %h 0 0",
                     seen, res_data, res_err, res_mismatch, want);
        end
        $display("mode0: data=%h err=%0d mm=%0b", res_data, res_err, res_mismatch);
    endtask

    task automatic test_timeout;
        int cyc; bit seen;
        start_job(1'b0, 64'h0102_0304_0506_0708, 1'b0, 4);
        wait_done(cyc, seen);
        total++;
        if (!seen || cyc != TO + 1) begin
            bad++;
            $display("FAIL timeout_latency got seen=%0b cyc=%0d want 1 %0d", seen, cyc, TO + 1);
        end
        total++;
        if ({res_data, res_err, res_mismatch} !== {108'd0, 2'd1, 1'b0}) begin
            bad++;
            $display("FAIL timeout_result got data=%h err=%0d mm=%0b want 0 1 0",
                     res_data, res_err, res_mismatch);
        end
        @(negedge clk);
        $display("timeout: cyc=%0d err=%0d", cyc, res_err);
    endtask

    task automatic test_short_burst;
        int cyc; bit seen;
        logic [107:0] want;
        want = {36'd0, 36'hB, 36'hA};
        start_job(1'b1, 64'h1111_2222_3333_4444, 1'b0, 4);
        respond(2, 36'hA, 36'hB, 36'hC);
        wait_done(cyc, seen);
        total++;
        if (!seen || cyc != 1) begin
            bad++;
            $display("FAIL short_latency got seen=%0b cyc=%0d want 1 1", seen, cyc);
        end
        total++;
        if ({res_data, res_err} !== {want, 2'd2}) begin
            bad++;
            $display("FAIL short_result got data=%h err=%0d want %h 2", res_data, res_err, want);
        end
        @(negedge clk);
        $display("short_burst: data=%h err=%0d", res_data, res_err);
    endtask

    task automatic test_early_output;
        int cyc; bit seen;
        start_job(1'b1, {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, 1'b1, 4);
        respond(3, 36'd15, 36'd0, 36'd15);
        wait_done(cyc, seen);
        total++;
        if (!seen || {res_err, res_mismatch} !== {2'd3, 1'b0}) begin
            bad++;
            $display("FAIL early_result got seen=%0b err=%0d mm=%0b want 1 3 0",
                     seen, res_err, res_mismatch);
        end
        @(negedge clk);
        $display("early_output: err=%0d", res_err);
    endtask

    task automatic test_reset_mid;
        int pulses;
        start_job(1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 2);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 2 * TO + 8; i++) begin
            if (res_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_mid_no_done got res_valid_cycles=%0d want 0", pulses);
        end
        total++;
        if ({job_ready, dut_in_valid, res_data, res_err} !== {1'b1, 1'b0, 108'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_mid_idle got ready=%0b in_v=%0b data=%h err=%0d want 1 0 0 0",
                     job_ready, dut_in_valid, res_data, res_err);
        end
        $display("reset_mid: ready=%0b", job_ready);
    endtask

    task automatic test_mismatch;
        int cyc; bit seen;
        logic want_mm;
`ifdef ONLINE_HOST_CHECK_EN
        want_mm = 1'b1;
`else
        want_mm = 1'b0;
`endif
        start_job(1'b1, {4{16'h5555}}, 1'b0, 4);
        respond(3, 36'd5, 36'd5, 36'd1);
        wait_done(cyc, seen);
        total++;
        if (!seen || {res_data, res_err, res_mismatch} !== {36'd1, 36'd5, 36'd5, 2'd0, want_mm}) begin
            bad++;
            $display("FAIL mismatch_bad got seen=%0b data=%h err=%0d mm=%0b want mm=%0b",
                     seen, res_data, res_err, res_mismatch, want_mm);
        end
        @(negedge clk);
        start_job(1'b1, {4{16'h5555}}, 1'b0, 4);
        respond(3, 36'd5, 36'd5, 36'd0);
        wait_done(cyc, seen);
        total++;
        if (!seen || {res_err, res_mismatch} !== {2'd0, 1'b0}) begin
            bad++;
            $display("FAIL mismatch_good got seen=%0b err=%0d mm=%0b want 1 0 0",
                     seen, res_err, res_mismatch);
        end
        @(negedge clk);
        $display("mismatch: mm=%0b", res_mismatch);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mode1();
        test_mode0();
        test_timeout();
        test_short_burst();
        test_early_output();
        test_reset_mid();
        test_mismatch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/online_host.md
ONLINE_HOST -- requirements
Module: online_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning max idle cycles waited for the first dut_out_valid after the last sent word.
REQ-002 SHALL have one clock and a reset that is asynchronous and active-low: port clk, input, 1 bit, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port job_valid, input, 1 bit, job request.
REQ-005 SHALL have port job_ready, output, 1 bit, high only in IDLE.
REQ-006 SHALL have port job_mode, input, 1 bit: 0 = complex product, 1 = nibble max/min.
REQ-007 SHALL have port job_data, input, 64 bits: word k at [16k+15:16k].
REQ-008 SHALL have port dut_in_valid, output, 1 bit, drives the DUT in_valid.
REQ-009 SHALL have port dut_in_mode, output, 1 bit, drives the DUT in_mode.
REQ-010 SHALL have port dut_in, output, 16 bits, drives the DUT in.
REQ-011 SHALL have port dut_out_valid, input, 1 bit, the DUT out_valid.
REQ-012 SHALL have port dut_out, input, 36 bits, the DUT out.
REQ-013 SHALL have port res_valid, output, 1 bit, one-cycle completion pulse.
REQ-014 SHALL have port res_data, output, 108 bits: result k at [36k+35:36k].
REQ-015 SHALL have port res_err, output, 2 bits: 0 ok, 1 timeout, 2 short burst, 3 early output.
REQ-016 SHALL have port res_mismatch, output, 1 bit, high when the checker disagrees with the DUT.

Function
REQ-017 SHALL implement FSM IDLE -> SEND -> WAIT -> RECV -> DONE -> IDLE.
REQ-018 SHALL accept a job on job_valid && job_ready, latching mode and data; SEND starts on the next cycle.
REQ-019 SHALL in SEND drive dut_in_valid=1 for exactly 4 consecutive cycles, with dut_in = word 0..3 in order.
REQ-020 SHALL drive dut_in_mode = the job mode in SEND cycle 0 only; it is 0 at all other times.
REQ-021 SHALL drive dut_in=0 and dut_in_valid=0 outside SEND.
REQ-022 SHALL on dut_out_valid=1 during SEND record err=3 and continue sending; the final res_err is 3.
REQ-023 SHALL in WAIT start a counter at 0 on the first cycle after word 3, incrementing each cycle.
REQ-024 SHALL in WAIT, on dut_out_valid=1, capture dut_out as result 0 and go to RECV.
REQ-025 SHALL in WAIT, when the counter reaches TIMEOUT-1 with no dut_out_valid, go to DONE with err=1; results are 0.
REQ-026 SHALL in RECV capture results 1 and 2 on the next two cycles.
REQ-027 SHALL in RECV, if dut_out_valid is low before result 2 arrives, go to DONE with err=2; uncaptured results are 0.
REQ-028 SHALL in DONE assert res_valid for one cycle, then return to IDLE.
REQ-029 SHALL hold res_data, res_err and res_mismatch stable until the next DONE.
REQ-030 SHALL treat job_valid as a don't-care outside IDLE; the job is not queued.

Reset
REQ-031 SHALL on rst_n=0 immediately force state IDLE, job_ready=1, and all other outputs and all counters and result registers to 0.
REQ-032 SHALL on reset asserted mid-job abandon the job without asserting res_valid.

Configuration
REQ-033 SHALL when ONLINE_HOST_CHECK_EN is defined compute expected results and set res_mismatch=1 at DONE if err=0 and any result differs.
REQ-034 SHALL define the mode-0 expected results with words 0,1 = A0,A1 and words 2,3 = B0,B1; in each word, real part = signed [15:8], imag part = signed [7:0].
REQ-035 SHALL define the mode-0 real parts as R0=Ar0Br0+Ai0Bi0, R1=Ar0Br1+Ai0Bi1+Ar1Br0+Ai1Bi0, R2=Ar1Br1+Ai1Bi1.
REQ-036 SHALL define the mode-0 imaginary parts as I0=Ar0Bi0-Ai0Br0, I1=Ar0Bi1-Ai0Br1+Ar1Bi0-Ai1Br0, I2=Ar1Bi1-Ai1Br1.
REQ-037 SHALL form each mode-0 result as {R[17:0], I[17:0]}.
REQ-038 SHALL define the mode-1 expected results over all 16 nibbles as {32'b0,max}, {32'b0,min}, {32'b0,max-min}.
REQ-039 SHALL when ONLINE_HOST_CHECK_EN is undefined tie res_mismatch to 0 and omit the checker logic.

Structure
REQ-040 SHALL put the FSM state typedef, the res_err code constants and the word/result widths (16, 36) in package online_pkg.
REQ-041 SHALL put the checker in sub-module online_ref_model, a combinational function of the latched mode and data, instantiated only under ONLINE_HOST_CHECK_EN.

Verification
REQ-042 SHALL cover mode 1 with words 0x1234,0x5678,0x9ABC,0xDEF0 and the DUT returning 15,0,15 -> res_data results 15,0,15, res_err=0, res_mismatch=0.
REQ-043 SHALL cover mode 0 with A0=(1,0), B0=(2,0), others 0, and the DUT returning 36'h000080000,0,0 -> res_err=0, res_mismatch=0.
REQ-044 SHALL cover a DUT that never raises out_valid -> res_valid exactly TIMEOUT+1 cycles after word 3, res_err=1.
REQ-045 SHALL cover a DUT with an out_valid burst of 2 cycles -> res_err=2, result 2 = 0.
REQ-046 SHALL cover rst_n pulsed low during SEND word 2 -> dut_in_valid=0 at once, no res_valid, job_ready=1.
REQ-047 SHALL cover, with ONLINE_HOST_CHECK_EN defined, mode 1 with all words 0x5555 and the DUT returning 5,5,1 -> res_mismatch=1.
